cp0_excpt_sched: RTL

Coprocessor-0 exception scheduler for the 5-stage MIPS core. It holds the Count, Compare, Status, Cause and EPC registers and arbitrates between the timer interrupt, SYSCALL and ERET presented by the MEM-stage instruction. It drives the pipeline-flush and exception-jump-PC signals consumed by the IF stage and the hazard unit.

---
 rtl/cp0_excpt_sched_pkg.sv | 49 ++++
 rtl/cp0_excpt_sched_if.sv | 38 +++
 rtl/cp0_excpt_sched_timer.sv | 55 +++++
 rtl/cp0_excpt_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cp0_excpt_sched_pkg.sv
// Shared constants and types for the CP0 exception scheduler:
// validity flags, one-hot exception codes, jump vectors, CP0 register
// numbers, ExcCode values and the mode/event enumerations.
// Optional timer logic is selected with the CP0_TIMER_EN macro.
package cp0_excpt_sched_pkg;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    // One-hot exception type codes reported on excptype_o
    localparam logic [31:0] EXC_COUNT_INT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS_INT   = 32'h0000_0002;
    localparam logic [31:0] EXC_ERET      = 32'h0000_0004;

    // Handler entry vectors
    localparam logic [31:0] COUNT_IPC = 32'h0000_0040;
    localparam logic [31:0] SYS_IPC   = 32'h0000_0080;

    // CP0 register numbers
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;

    // Mode is Status.EXL
    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_e;

    // Winner of the MEM-stage arbitration
    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_TIMER   = 2'd1,
        EV_SYSCALL = 2'd2,
        EV_ERET    = 2'd3
    } event_e;

    // Cause layout: bit15 IP7, bits[6:2] ExcCode
    function automatic logic [31:0] make_cause(input logic ip7, input logic [4:0] exccode);
        return {16'h0000, ip7, 8'h00, exccode, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_excpt_sched_if.sv
// MEM-stage to CP0 interface. The pipeline (master) presents the
// MEM-stage instruction and MTC0/MFC0 ports; CP0 (slave) answers with
// read data and a same-cycle flush/redirect.
// Handshake: there is no back-pressure. mem_valid_i qualifies the
// instruction fields for the current cycle only; excpt_o, excptype_o and
// ejpc_o answer that same cycle, and a write whose cycle has excpt_o=1
// is discarded.
interface cp0_excpt_sched_if;
    import cp0_excpt_sched_pkg::*;

    logic        mem_valid_i;
    logic [31:0] inst_pc_i;
    logic        syscall_i;
    logic        eret_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [4:0]  cp0_raddr_i;
    logic [31:0] cp0_rdata_o;
    logic [31:0] excptype_o;
    logic        excpt_o;
    logic [31:0] ejpc_o;
    logic        timer_int_o;
    mode_e       mode_o;

    modport master (
        output mem_valid_i, inst_pc_i, syscall_i, eret_i,
        output cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
        input  cp0_rdata_o, excptype_o, excpt_o, ejpc_o, timer_int_o, mode_o
    );

    modport slave (
        input  mem_valid_i, inst_pc_i, syscall_i, eret_i,
        input  cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
        output cp0_rdata_o, excptype_o, excpt_o, ejpc_o, timer_int_o, mode_o
    );

endinterface

// File: rtl/cp0_excpt_sched_timer.sv
// cp0_timer: Count/Compare registers, match detector and the IP7
// pending flag. Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_excpt_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        clr_pend_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ip7_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ip7_q, ip7_d;
    // Low for the first cycle after reset so Count=Compare=0 cannot fire
    logic        armed_q, armed_d;

    // Next-state: free-running count, MTC0 overrides, sticky match flag
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ip7_d     = ip7_q;
        armed_d   = 1'b1;
        if (we_i && waddr_i == CP0_COUNT)   count_d   = wdata_i;
        if (we_i && waddr_i == CP0_COMPARE) compare_d = wdata_i;
        if (armed_q && count_q == compare_q) ip7_d = 1'b1;
        // A Compare write clears the pending flag, even over a new match
        if (clr_pend_i) ip7_d = 1'b0;
    end

    // Timer register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ip7_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
            armed_q   <= armed_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ip7_o     = ip7_q;

endmodule

// File: rtl/cp0_excpt_sched.sv
// cp0_excpt_sched: CP0 Status/Cause/EPC, MEM-stage exception arbiter
// (timer > SYSCALL > ERET) and MFC0 read mux. Count/Compare/IP7 live in
// cp0_timer, present only when CP0_TIMER_EN is defined.
module cp0_excpt_sched
    import cp0_excpt_sched_pkg::*;
#(
    parameter logic [31:0] RESET_STATUS = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    cp0_excpt_sched_if.slave bus
);

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] count, compare;
    logic        ip7;
    logic        we_eff;
    event_e      ev;
    mode_e       mode;

    // Writes from a flushed instruction never land
    assign we_eff = bus.cp0_we_i && (ev == EV_NONE);

`ifdef CP0_TIMER_EN
    logic clr_pend;
    assign clr_pend = we_eff && (bus.cp0_waddr_i == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_eff),
        .waddr_i    (bus.cp0_waddr_i),
        .wdata_i    (bus.cp0_wdata_i),
        .clr_pend_i (clr_pend),
        .count_o    (count),
        .compare_o  (compare),
        .ip7_o      (ip7)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ip7     = 1'b0;
`endif

    // Mode decode: EXL is the mode state
    always_comb begin
        mode = MODE_NORMAL;
        if (status_q[1]) mode = MODE_HANDLER;
    end

    // Arbitration of the MEM-stage instruction, timer first
    always_comb begin
        ev = EV_NONE;
        if (!rst && bus.mem_valid_i) begin
            if (ip7 && status_q[0] && !status_q[1]) ev = EV_TIMER;
            else if (bus.syscall_i)                 ev = EV_SYSCALL;
            else if (bus.eret_i)                    ev = EV_ERET;
        end
    end

    // Same-cycle redirect outputs
    always_comb begin
        bus.excpt_o    = INVALID;
        bus.excptype_o = 32'd0;
        bus.ejpc_o     = 32'd0;
        case (ev)
            EV_TIMER:   begin bus.excpt_o = VALID; bus.excptype_o = EXC_COUNT_INT; bus.ejpc_o = COUNT_IPC; end
            EV_SYSCALL: begin bus.excpt_o = VALID; bus.excptype_o = EXC_SYS_INT;   bus.ejpc_o = SYS_IPC;   end
            EV_ERET:    begin bus.excpt_o = VALID; bus.excptype_o = EXC_ERET;      bus.ejpc_o = epc_q;     end
            default:    ;
        endcase
    end

    // Next Status/Cause/EPC from MTC0 or the winning event
    always_comb begin
        status_d  = status_q;
        epc_d     = epc_q;
        exccode_d = exccode_q;
        if (we_eff && bus.cp0_waddr_i == CP0_STATUS) status_d = bus.cp0_wdata_i;
        case (ev)
            EV_TIMER: begin
                epc_d       = bus.inst_pc_i;
                status_d[1] = 1'b1;
                exccode_d   = EXCCODE_INT;
            end
            EV_SYSCALL: begin
                // A nested SYSCALL keeps the original return address
                if (!status_q[1]) epc_d = bus.inst_pc_i + 32'd4;
                status_d[1] = 1'b1;
                exccode_d   = EXCCODE_SYS;
            end
            EV_ERET: status_d[1] = 1'b0;
            default: ;
        endcase
    end

    // CP0 register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= RESET_STATUS;
            epc_q     <= 32'd0;
            exccode_q <= 5'd0;
        end else begin
            status_q  <= status_d;
            epc_q     <= epc_d;
            exccode_q <= exccode_d;
        end
    end

    // MFC0 read mux, pre-edge state only
    always_comb begin
        bus.cp0_rdata_o = 32'd0;
        if (!rst) begin
            case (bus.cp0_raddr_i)
                CP0_COUNT:   bus.cp0_rdata_o = count;
                CP0_COMPARE: bus.cp0_rdata_o = compare;
                CP0_STATUS:  bus.cp0_rdata_o = status_q;
                CP0_CAUSE:   bus.cp0_rdata_o = make_cause(ip7, exccode_q);
                CP0_EPC:     bus.cp0_rdata_o = epc_q;
                default:     bus.cp0_rdata_o = 32'd0;
            endcase
        end
    end

    assign bus.timer_int_o = ip7;
    assign bus.mode_o      = mode;

endmodule
